// File: rtl/dcache_nway.sv
// dcache_nway: N-way set-associative, write-back, write-allocate data cache
// for the MEM stage. Lookup is combinational from addr; a miss holds the
// pipeline (stall) while the FSM writes back a dirty victim and refills
// the line one 32-bit word per memory handshake.
//
// Ports:
//   clk, rst          clock, synchronous active-low reset
//   addr, wdata       byte address and right-aligned store data
//   rd_en, wr_en      load / store request (mutually exclusive)
//   addressing_mode   RV funct3 (B, H, W, BU, HU)
//   rdata             extended load data (0 when no load completes)
//   stall             request not complete this cycle
//   mem_req/mem_we    line-transfer beat request, 1 = writeback beat
//   mem_addr          word-aligned beat address
//   mem_wdata         writeback word
//   mem_rdata         refill word
//   mem_ready         beat completes on mem_req && mem_ready
//   hit_count         completed hits
//   miss_count        detected misses
module dcache_nway #(
   parameter int WAYS       = 2,
   parameter int SETS       = 16,
   parameter int LINE_WORDS = 4,
   parameter int ADDR_WIDTH = 32
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic [ADDR_WIDTH-1:0] addr,
   input  logic [31:0]           wdata,
   input  logic                  rd_en,
   input  logic                  wr_en,
   input  logic [2:0]            addressing_mode,
   output logic [31:0]           rdata,
   output logic                  stall,
   output logic                  mem_req,
   output logic                  mem_we,
   output logic [ADDR_WIDTH-1:0] mem_addr,
   output logic [31:0]           mem_wdata,
   input  logic [31:0]           mem_rdata,
   input  logic                  mem_ready,
   output logic [31:0]           hit_count,
   output logic [31:0]           miss_count
);

   localparam int WORD_BITS = $clog2(LINE_WORDS);
   localparam int SET_BITS  = $clog2(SETS);
   localparam int WAY_BITS  = (WAYS > 1) ? $clog2(WAYS) : 1;
   localparam int TAG_BITS  = ADDR_WIDTH - 2 - WORD_BITS - SET_BITS;

   typedef enum logic [1:0] {
      IDLE,
      WRITEBACK,
      REFILL
   } stateT;

   stateT state;

   // Cache storage
   logic [WAYS-1:0]     validArr [SETS];
   logic [WAYS-1:0]     dirtyArr [SETS];
   logic [WAY_BITS-1:0] ptrArr   [SETS];
   logic [TAG_BITS-1:0] tagArr   [SETS][WAYS];
   logic [31:0]         dataArr  [SETS][WAYS][LINE_WORDS];

   // Miss-handling registers
   logic [WAY_BITS-1:0]  victimWay;
   logic [TAG_BITS-1:0]  victimTag;
   logic [WORD_BITS-1:0] beat;
   logic [31:0]          hitCnt;
   logic [31:0]          missCnt;

   // Address fields
   logic [WORD_BITS-1:0] wordIdx;
   logic [SET_BITS-1:0]  setIdx;
   logic [TAG_BITS-1:0]  reqTag;

   assign wordIdx = addr[2 +: WORD_BITS];
   assign setIdx  = addr[2 + WORD_BITS +: SET_BITS];
   assign reqTag  = addr[ADDR_WIDTH-1 -: TAG_BITS];

   logic                reqActive;
   logic                hit;
   logic [WAY_BITS-1:0] hitWay;
   logic                invFound;
   logic [WAY_BITS-1:0] invWay;
   logic [WAY_BITS-1:0] victimSel;
   logic [WAY_BITS-1:0] nextPtr;
   logic                lastBeat;

   assign reqActive = rd_en | wr_en;
   assign lastBeat  = (beat == WORD_BITS'(LINE_WORDS - 1));

   // Tag compare across all ways of the addressed set
   always_comb begin
      hit    = 1'b0;
      hitWay = '0;
      for (int unsigned w = 0; w < WAYS; w++) begin
         if (validArr[setIdx][w[WAY_BITS-1:0]] &&
             (tagArr[setIdx][w[WAY_BITS-1:0]] == reqTag)) begin
            hit    = 1'b1;
            hitWay = w[WAY_BITS-1:0];
         end
      end
   end

   // Victim: lowest invalid way, otherwise the set's round-robin pointer
   always_comb begin
      invFound = 1'b0;
      invWay   = '0;
      for (int unsigned w = 0; w < WAYS; w++) begin
         if (!invFound && !validArr[setIdx][w[WAY_BITS-1:0]]) begin
            invFound = 1'b1;
            invWay   = w[WAY_BITS-1:0];
         end
      end
      victimSel = invFound ? invWay : ptrArr[setIdx];
      nextPtr   = (ptrArr[setIdx] == WAY_BITS'(WAYS - 1)) ? '0 : ptrArr[setIdx] + 1'b1;
   end

   // Load extraction and store merge on the hit word
   logic [31:0] curWord;
   logic [31:0] byteShift;
   logic [31:0] halfShift;
   logic [7:0]  byteVal;
   logic [15:0] halfVal;
   logic [31:0] storeWord;

   always_comb begin
      curWord   = dataArr[setIdx][hitWay][wordIdx];
      byteShift = curWord >> {addr[1:0], 3'b000};
      halfShift = curWord >> {addr[1], 4'b0000};
      byteVal   = byteShift[7:0];
      halfVal   = halfShift[15:0];

      storeWord = curWord;
      case (addressing_mode[1:0])
         2'b00:   storeWord[{addr[1:0], 3'b000} +: 8]  = wdata[7:0];
         2'b01:   storeWord[{addr[1], 4'b0000} +: 16] = wdata[15:0];
         default: storeWord = wdata;
      endcase

      rdata = '0;
      if ((state == IDLE) && rd_en && hit) begin
         case (addressing_mode)
            3'b000:  rdata = {{24{byteVal[7]}}, byteVal};
            3'b001:  rdata = {{16{halfVal[15]}}, halfVal};
            3'b100:  rdata = {24'd0, byteVal};
            3'b101:  rdata = {16'd0, halfVal};
            default: rdata = curWord;
         endcase
      end
   end

   assign stall      = (state != IDLE) || (reqActive && !hit);
   assign mem_req    = (state != IDLE);
   assign mem_we     = (state == WRITEBACK);
   assign mem_addr   = (state == WRITEBACK) ? {victimTag, setIdx, beat, 2'b00}
                                            : {reqTag, setIdx, beat, 2'b00};
   assign mem_wdata  = dataArr[setIdx][victimWay][beat];
   assign hit_count  = hitCnt;
   assign miss_count = missCnt;

   // Control FSM, status bits and counters
   always_ff @(posedge clk) begin
      if (!rst) begin
         state     <= IDLE;
         beat      <= '0;
         victimWay <= '0;
         victimTag <= '0;
         hitCnt    <= '0;
         missCnt   <= '0;
         for (int unsigned s = 0; s < SETS; s++) begin
            validArr[s[SET_BITS-1:0]] <= '0;
            dirtyArr[s[SET_BITS-1:0]] <= '0;
            ptrArr[s[SET_BITS-1:0]]   <= '0;
         end
      end else begin
         case (state)
            IDLE: begin
               if (reqActive) begin
                  if (hit) begin
                     hitCnt <= hitCnt + 32'd1;
                     if (wr_en) dirtyArr[setIdx][hitWay] <= 1'b1;
                  end else begin
                     missCnt   <= missCnt + 32'd1;
                     victimWay <= victimSel;
                     victimTag <= tagArr[setIdx][victimSel];
                     beat      <= '0;
                     if (!invFound) ptrArr[setIdx] <= nextPtr;
                     if (validArr[setIdx][victimSel] && dirtyArr[setIdx][victimSel])
                        state <= WRITEBACK;
                     else
                        state <= REFILL;
                  end
               end
            end
            WRITEBACK: begin
               if (mem_ready) begin
                  beat <= beat + 1'b1;
                  if (lastBeat) begin
                     beat  <= '0;
                     state <= REFILL;
                  end
               end
            end
            REFILL: begin
               if (mem_ready) begin
                  beat <= beat + 1'b1;
                  if (lastBeat) begin
                     beat                        <= '0;
                     validArr[setIdx][victimWay] <= 1'b1;
                     dirtyArr[setIdx][victimWay] <= 1'b0;
                     state                       <= IDLE;
                  end
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

   // Tag and data arrays need no reset; valid bits qualify them
   always_ff @(posedge clk) begin
      if (rst) begin
         if ((state == REFILL) && mem_ready) begin
            dataArr[setIdx][victimWay][beat] <= mem_rdata;
            if (lastBeat) tagArr[setIdx][victimWay] <= reqTag;
         end else if ((state == IDLE) && wr_en && hit) begin
            dataArr[setIdx][hitWay][wordIdx] <= storeWord;
         end
      end
   end

endmodule

// File: tb/tb_dcache_nway.sv
module tb_dcache_nway;

   localparam int WAYS = 2;
   localparam int SETS = 16;

   logic        clk = 1'b0;
   logic        rst;
   logic [31:0] addr;
   logic [31:0] wdata;
   logic        rd_en;
   logic        wr_en;
   logic [2:0]  addressing_mode;
   logic [31:0] rdata;
   logic        stall;
   logic        mem_req;
   logic        mem_we;
   logic [31:0] mem_addr;
   logic [31:0] mem_wdata;
   logic [31:0] mem_rdata;
   logic        mem_ready;
   logic [31:0] hit_count;
   logic [31:0] miss_count;

   always #5 clk = ~clk;

   dcache_nway #(.WAYS(WAYS), .SETS(SETS), .LINE_WORDS(4), .ADDR_WIDTH(32)) dut (
      .clk(clk), .rst(rst), .addr(addr), .wdata(wdata), .rd_en(rd_en), .wr_en(wr_en),
      .addressing_mode(addressing_mode), .rdata(rdata), .stall(stall),
      .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
      .mem_rdata(mem_rdata), .mem_ready(mem_ready),
      .hit_count(hit_count), .miss_count(miss_count)
   );

   // Backing memory (what main memory holds) and architectural memory
   // (what a load must return, i.e. backing memory plus all stores)
   logic [31:0] backMem [0:1023];
   logic [31:0] archMem [0:1023];
   assign mem_rdata = backMem[mem_addr[11:2]];

   int total = 0;
   int bad   = 0;
   int holdErr = 0;

   bit readyPat [0:255];

   logic        obsWe[$];
   logic [31:0] obsAddr[$];
   logic [31:0] obsData[$];
   logic        expWe[$];
   logic [31:0] expAddr[$];
   logic [31:0] expData[$];

   // Reference cache directory: which tag each way holds
   bit mV [SETS][WAYS];
   bit mD [SETS][WAYS];
   int mTag [SETS][WAYS];
   int mPtr [SETS];
   int mHits;
   int mMisses;

   function automatic void modelReset();
      for (int s = 0; s < SETS; s++) begin
         mPtr[s] = 0;
         for (int w = 0; w < WAYS; w++) begin
            mV[s][w] = 0; mD[s][w] = 0; mTag[s][w] = 0;
         end
      end
      mHits = 0;
      mMisses = 0;
      for (int i = 0; i < 1024; i++) archMem[i] = backMem[i];
   endfunction

   function automatic void fillReady(input int m);
      for (int i = 0; i < 256; i++) begin
         if (m == 0)      readyPat[i] = 1'b1;
         else if (m == 1) readyPat[i] = (i % 2 == 0);
         else             readyPat[i] = ($urandom_range(0, 9) < 7);
      end
   endfunction

   // Stall length: the miss cycle plus every cycle until nBeats ready cycles
   function automatic int expStallOf(input int nBeats);
      int got = 0;
      if (nBeats == 0) return 0;
      for (int i = 1; i < 256; i++) begin
         if (readyPat[i]) got++;
         if (got == nBeats) return i + 1;
      end
      return -2;
   endfunction

   function automatic logic [31:0] loadValue(input logic [31:0] word, input logic [31:0] a,
                                             input logic [2:0] md);
      logic [7:0]  b;
      logic [15:0] h;
      b = 8'((word >> (8 * a[1:0])) & 32'hFF);
      h = 16'((word >> (16 * a[1])) & 32'hFFFF);
      case (md)
         3'b000:  return {{24{b[7]}}, b};
         3'b001:  return {{16{h[15]}}, h};
         3'b100:  return {24'd0, b};
         3'b101:  return {16'd0, h};
         default: return word;
      endcase
   endfunction

   task automatic modelAccess(input logic [31:0] a, input bit wr, input logic [2:0] md,
                              input logic [31:0] wd, output int nBeats, output logic [31:0] expRd);
      int s, t, hw, v;
      logic [31:0] ba, mask, ins;
      s = int'((a >> 4) & 15);
      t = int'(a >> 8);
      hw = -1;
      expWe.delete(); expAddr.delete(); expData.delete();
      for (int w = 0; w < WAYS; w++) if (mV[s][w] && mTag[s][w] == t) hw = w;
      if (hw < 0) begin
         mMisses++;
         v = -1;
         for (int w = WAYS - 1; w >= 0; w--) if (!mV[s][w]) v = w;
         if (v < 0) begin
            v = mPtr[s];
            mPtr[s] = (mPtr[s] + 1) % WAYS;
         end
         if (mV[s][v] && mD[s][v]) begin
            for (int i = 0; i < 4; i++) begin
               ba = 32'((mTag[s][v] << 8) | (s << 4) | (i << 2));
               expWe.push_back(1'b1); expAddr.push_back(ba); expData.push_back(archMem[ba[11:2]]);
            end
         end
         for (int i = 0; i < 4; i++) begin
            ba = 32'((t << 8) | (s << 4) | (i << 2));
            expWe.push_back(1'b0); expAddr.push_back(ba); expData.push_back(32'd0);
         end
         mV[s][v] = 1; mD[s][v] = 0; mTag[s][v] = t;
         hw = v;
      end
      mHits++;
      expRd = loadValue(archMem[a[11:2]], a, md);
      if (wr) begin
         case (md[1:0])
            2'b00:   begin mask = 32'hFF << (8 * a[1:0]);    ins = (wd & 32'hFF) << (8 * a[1:0]); end
            2'b01:   begin mask = 32'hFFFF << (16 * a[1]);   ins = (wd & 32'hFFFF) << (16 * a[1]); end
            default: begin mask = 32'hFFFFFFFF;              ins = wd; end
         endcase
         archMem[a[11:2]] = (archMem[a[11:2]] & ~mask) | ins;
         mD[s][hw] = 1;
      end
      nBeats = expWe.size();
   endtask

   // Drives one request until stall drops; logs handshake beats and
   // counts any change of beat outputs while mem_ready is low
   task automatic runAccess(input bit wr, input bit rd, input logic [31:0] a, input logic [2:0] md,
                            input logic [31:0] wd, output int stallCyc, output logic [31:0] rdv);
      logic [64:0] held;
      bit holding, done;
      obsWe.delete(); obsAddr.delete(); obsData.delete();
      stallCyc = 0; rdv = '0; holding = 0; done = 0; held = '0;
      @(negedge clk);
      addr = a; wdata = wd; addressing_mode = md; rd_en = rd; wr_en = wr;
      for (int i = 0; i < 256; i++) begin
         mem_ready = readyPat[i];
         #1;
         if (holding && ({mem_we, mem_addr, mem_wdata} !== held)) holdErr++;
         holding = mem_req && !mem_ready;
         held = {mem_we, mem_addr, mem_wdata};
         if (!stall) begin
            rdv = rdata;
            done = 1;
            break;
         end
         stallCyc++;
         if (mem_req && mem_ready) begin
            obsWe.push_back(mem_we); obsAddr.push_back(mem_addr); obsData.push_back(mem_wdata);
            if (mem_we) backMem[mem_addr[11:2]] = mem_wdata;
         end
         @(negedge clk);
      end
      if (!done) stallCyc = -1;
      @(posedge clk);
      #1;
      rd_en = 0; wr_en = 0; mem_ready = 1;
   endtask

   task automatic doReset();
      @(negedge clk);
      rst = 0; rd_en = 0; wr_en = 0; mem_ready = 1;
      @(negedge clk);
      @(negedge clk);
      rst = 1;
      modelReset();
   endtask

   task automatic test_reset();
      doReset();
      #1;
      total++; if (stall !== 1'b0)   begin bad++; $display("FAIL reset_stall got=%b want=0", stall); end
      total++; if (mem_req !== 1'b0) begin bad++; $display("FAIL reset_mem_req got=%b want=0", mem_req); end
      total++; if (mem_we !== 1'b0)  begin bad++; $display("FAIL reset_mem_we got=%b want=0", mem_we); end
      total++; if (rdata !== 32'd0)  begin bad++; $display("FAIL reset_rdata got=%h want=0", rdata); end
      total++; if (hit_count !== 32'd0 || miss_count !== 32'd0) begin
         bad++; $display("FAIL reset_counts got=%0d/%0d want=0/0", hit_count, miss_count);
      end
   endtask

   task automatic test_first_miss();
      int sc, nb; logic [31:0] rv, er;
      fillReady(0);
      modelAccess(32'h0, 0, 3'b010, 32'd0, nb, er);
      runAccess(0, 1, 32'h0, 3'b010, 32'd0, sc, rv);
      total++; if (sc !== 5) begin bad++; $display("FAIL first_stall got=%0d want=5", sc); end
      total++; if (rv !== 32'd0) begin bad++; $display("FAIL first_rdata got=%h want=0", rv); end
      total++;
      if (obsAddr.size() != 4) begin bad++; $display("FAIL first_beats got=%0d want=4", obsAddr.size()); end
      else for (int k = 0; k < 4; k++) begin
         total++;
         if (obsAddr[k] !== 32'(k * 4) || obsWe[k] !== 1'b0) begin
            bad++; $display("FAIL first_beat%0d got=%h/%b want=%h/0", k, obsAddr[k], obsWe[k], k * 4);
         end
      end
      total++; if (miss_count !== 32'd1 || hit_count !== 32'd1) begin
         bad++; $display("FAIL first_counts got=%0d/%0d want=1/1", miss_count, hit_count);
      end
   endtask

   task automatic test_hit();
      int sc, nb; logic [31:0] rv, er;
      fillReady(0);
      modelAccess(32'h4, 0, 3'b010, 32'd0, nb, er);
      runAccess(0, 1, 32'h4, 3'b010, 32'd0, sc, rv);
      total++; if (sc !== 0) begin bad++; $display("FAIL hit_stall got=%0d want=0", sc); end
      total++; if (rv !== 32'd1) begin bad++; $display("FAIL hit_rdata got=%h want=1", rv); end
   endtask

   task automatic test_byte_half();
      int sc, nb; logic [31:0] rv, er;
      logic [31:0] ta [6] = '{32'h5, 32'h5, 32'h5, 32'h6, 32'h6, 32'h6};
      logic [2:0]  tm [6] = '{3'b000, 3'b000, 3'b100, 3'b001, 3'b001, 3'b101};
      logic [31:0] td [6] = '{32'hFF, 32'h0, 32'h0, 32'h8001, 32'h0, 32'h0};
      bit          tw [6] = '{1, 0, 0, 1, 0, 0};
      logic [31:0] te [6] = '{32'h0, 32'hFFFFFFFF, 32'h000000FF, 32'h0, 32'hFFFF8001, 32'h00008001};
      fillReady(0);
      for (int i = 0; i < 6; i++) begin
         modelAccess(ta[i], tw[i], tm[i], td[i], nb, er);
         runAccess(tw[i], !tw[i], ta[i], tm[i], td[i], sc, rv);
         total++; if (sc !== 0) begin bad++; $display("FAIL bh_stall%0d got=%0d want=0", i, sc); end
         if (!tw[i]) begin
            total++; if (rv !== te[i]) begin bad++; $display("FAIL bh_rdata%0d got=%h want=%h", i, rv, te[i]); end
         end
      end
   endtask

   task automatic test_conflict();
      int sc, nb; logic [31:0] rv, er;
      fillReady(0);
      modelAccess(32'h0, 1, 3'b010, 32'hDEADBEEF, nb, er);
      runAccess(1, 0, 32'h0, 3'b010, 32'hDEADBEEF, sc, rv);
      modelAccess(32'h100, 0, 3'b010, 32'd0, nb, er);
      runAccess(0, 1, 32'h100, 3'b010, 32'd0, sc, rv);
      total++; if (sc !== 5) begin bad++; $display("FAIL conf_fill_stall got=%0d want=5", sc); end
      modelAccess(32'h200, 0, 3'b010, 32'd0, nb, er);
      runAccess(0, 1, 32'h200, 3'b010, 32'd0, sc, rv);
      total++; if (sc !== 9) begin bad++; $display("FAIL conf_stall got=%0d want=9", sc); end
      total++; if (rv !== 32'h80) begin bad++; $display("FAIL conf_rdata got=%h want=80", rv); end
      total++;
      if (obsAddr.size() != 8) begin bad++; $display("FAIL conf_beats got=%0d want=8", obsAddr.size()); end
      else begin
         total++; if (obsData[0] !== 32'hDEADBEEF || obsData[1] !== 32'h8001FF01) begin
            bad++; $display("FAIL conf_wbdata got=%h,%h want=deadbeef,8001ff01", obsData[0], obsData[1]);
         end
         for (int k = 0; k < 8; k++) begin
            total++;
            if (obsWe[k] !== (k < 4) || obsAddr[k] !== ((k < 4) ? 32'(k * 4) : 32'(32'h200 + (k - 4) * 4))) begin
               bad++; $display("FAIL conf_beat%0d got=%b/%h", k, obsWe[k], obsAddr[k]);
            end
         end
      end
   endtask

   task automatic test_toggle_ready();
      int sc, nb; logic [31:0] rv, er;
      int h0;
      h0 = holdErr;
      fillReady(1);
      modelAccess(32'h348, 0, 3'b010, 32'd0, nb, er);
      runAccess(0, 1, 32'h348, 3'b010, 32'd0, sc, rv);
      total++; if (sc !== 9) begin bad++; $display("FAIL tog_stall got=%0d want=9", sc); end
      total++; if (rv !== 32'h0D2) begin bad++; $display("FAIL tog_rdata got=%h want=d2", rv); end
      total++; if (holdErr !== h0) begin bad++; $display("FAIL tog_hold got=%0d want=%0d", holdErr, h0); end
   endtask

   task automatic test_random();
      int nb, sc, es; logic [31:0] a, wd, er, rv; logic [2:0] md; bit wr;
      for (int n = 0; n < 250; n++) begin
         wr = ($urandom_range(0, 2) == 0);
         a  = 32'($urandom_range(0, 4095));
         wd = $urandom;
         if (wr) md = 3'($urandom_range(0, 2));
         else case ($urandom_range(0, 4))
            0: md = 3'b000; 1: md = 3'b001; 2: md = 3'b010; 3: md = 3'b100; default: md = 3'b101;
         endcase
         fillReady(2);
         modelAccess(a, wr, md, wd, nb, er);
         es = expStallOf(nb);
         runAccess(wr, !wr, a, md, wd, sc, rv);
         total++; if (sc !== es) begin bad++; $display("FAIL rnd_stall n=%0d a=%h got=%0d want=%0d", n, a, sc, es); end
         if (!wr) begin
            total++; if (rv !== er) begin bad++; $display("FAIL rnd_rdata n=%0d a=%h got=%h want=%h", n, a, rv, er); end
         end
         total++;
         if (obsAddr.size() != nb) begin
            bad++; $display("FAIL rnd_beats n=%0d got=%0d want=%0d", n, obsAddr.size(), nb);
         end else for (int k = 0; k < nb; k++) begin
            total++;
            if (obsWe[k] !== expWe[k] || obsAddr[k] !== expAddr[k] || (expWe[k] && obsData[k] !== expData[k])) begin
               bad++; $display("FAIL rnd_beat n=%0d k=%0d got=%b/%h/%h want=%b/%h/%h", n, k,
                               obsWe[k], obsAddr[k], obsData[k], expWe[k], expAddr[k], expData[k]);
            end
         end
      end
      total++; if (hit_count !== 32'(mHits) || miss_count !== 32'(mMisses)) begin
         bad++; $display("FAIL rnd_counts got=%0d/%0d want=%0d/%0d", hit_count, miss_count, mHits, mMisses);
      end
      total++; if (holdErr !== 0) begin bad++; $display("FAIL rnd_hold got=%0d want=0", holdErr); end
   endtask

   task automatic test_mid_reset();
      int sc, nb; logic [31:0] rv, er;
      bit found;
      doReset();
      fillReady(0);
      found = 0;
      @(negedge clk);
      addr = 32'h0; addressing_mode = 3'b010; rd_en = 1; mem_ready = 1;
      for (int i = 0; i < 20; i++) begin
         #1;
         if (mem_req && mem_addr == 32'h8) begin
            rst = 0; rd_en = 0; found = 1;
            break;
         end
         @(negedge clk);
      end
      total++; if (!found) begin bad++; $display("FAIL mid_beat2 got=0 want=1"); end
      @(negedge clk);
      #1;
      rd_en = 0;
      total++; if (mem_req !== 1'b0) begin bad++; $display("FAIL mid_mem_req got=%b want=0", mem_req); end
      rst = 1;
      modelReset();
      modelAccess(32'h0, 0, 3'b010, 32'd0, nb, er);
      runAccess(0, 1, 32'h0, 3'b010, 32'd0, sc, rv);
      total++; if (sc !== 5) begin bad++; $display("FAIL mid_remiss_stall got=%0d want=5", sc); end
      total++; if (miss_count !== 32'd1) begin bad++; $display("FAIL mid_miss_count got=%0d want=1", miss_count); end
      total++; if (rv !== er) begin bad++; $display("FAIL mid_rdata got=%h want=%h", rv, er); end
   endtask

   initial begin
      rst = 1; rd_en = 0; wr_en = 0; addr = '0; wdata = '0; addressing_mode = 3'b010; mem_ready = 1;
      for (int i = 0; i < 1024; i++) backMem[i] = 32'(i);
      test_reset();
      test_first_miss();
      test_hit();
      test_byte_half();
      test_conflict();
      test_toggle_ready();
      test_random();
      test_mid_reset();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
